memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
Shares one word-wide read/write memory between two requesters: port 0 is instruction fetch (read-only) and port 1 is data load/store (read/write with byte enables). The memory has an asynchronous read, a synchronous write and no byte enables. This block arbitrates between the two ports and converts partial-word stores into a read-modify-write sequence. It sits between the core's fetch/LSU stages and the memory instance.

Parameters:
DATA_WIDTH, 32, memory word width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, byte-address width.

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_p0_req  in  1  port 0 read request; held high until ack
i_p0_addr  in  ADDR_WIDTH  port 0 byte address
o_p0_ack  out  1  port 0 transaction complete, one-cycle pulse
o_p0_rdata  out  DATA_WIDTH  port 0 read data, valid while o_p0_ack is high
i_p1_req  in  1  port 1 request; held high until ack
i_p1_addr  in  ADDR_WIDTH  port 1 byte address
i_p1_we  in  1  port 1 write
i_p1_be  in  DATA_WIDTH/8  port 1 byte enables
i_p1_wdata  in  DATA_WIDTH  port 1 write data
o_p1_ack  out  1  port 1 transaction complete, one-cycle pulse
o_p1_rdata  out  DATA_WIDTH  port 1 read data
o_mem_addr  out  ADDR_WIDTH  memory address; low log2(DATA_WIDTH/8) bits always 0
o_mem_we  out  1  memory write enable
o_mem_wdata  out  DATA_WIDTH  memory write data
i_mem_rdata  in  DATA_WIDTH  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset values: state=IDLE, o_p0_ack=0, o_p1_ack=0, o_p0_rdata=0, o_p1_rdata=0, o_mem_we=0, o_mem_wdata=0, o_mem_addr=0, last_grant=1.
- Requester protocol:
  - Requester holds req, addr, we, be and wdata stable until it samples ack=1.
  - Dropping req after grant is illegal; the granted transaction still completes and acks.
- FSM states: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
- IDLE arbitration:
  - Only one request: grant it.
  - Both requesting: grant the port != last_grant (round-robin).
  - On grant: latch port, address (word-aligned), we, be and wdata; update last_grant.
- IDLE next-state:
  - Read, or we=1 with be=0: READ.
  - we=1 with all be set: WRITE.
  - Otherwise: RMW_READ.
- READ: o_mem_addr=latched addr; capture i_mem_rdata into the granted port's rdata register; go to DONE.
- WRITE: o_mem_we=1, o_mem_wdata=latched wdata; go to DONE.
- RMW_READ: capture the old word; go to RMW_WRITE.
- RMW_WRITE: o_mem_we=1; o_mem_wdata = per byte, wdata where be=1, else the old word; go to DONE.
- DONE: granted port's ack=1 for exactly one cycle; next state is IDLE unconditionally.
- Latency from req to ack (req seen in IDLE at cycle 0, ack high in the cycle shown):
  - Read: cycle 2.
  - Full write: cycle 2.
  - RMW: cycle 3.
  - No new grant until the cycle after DONE.
- Output rules:
  - o_mem_we=0 in every state except WRITE and RMW_WRITE.
  - On writes, o_p1_rdata holds its previous value.
  - rdata registers change only in READ.
- Reset asserted mid-transaction: immediate return to IDLE with all reset values; no write is issued; the interrupted requester receives no ack.

Optional Feature:
MEMORY_ARBITER_DATA_PRIORITY_EN
- Defined: fixed priority; port 1 always wins a simultaneous request. last_grant is still updated but ignored.
- Undefined: round-robin as described above.

Decomposition:
- Package memory_arbiter_pkg contains:
  - the FSM state enum;
  - port index constants PORT_FETCH=0 and PORT_DATA=1;
  - a localparam helper for BE width (DATA_WIDTH/8) and the alignment-bit count.
- One combinational sub-module, byte_merge, takes (old, new, be) and produces the merged word. It is reused by the LSU store path.

Test Plan:
- p0 read of 0x0000_0010, memory word 0xDEADBEEF -> o_p0_ack pulse at cycle 2 with o_p0_rdata=0xDEADBEEF; o_mem_addr=0x10; o_mem_we never 1.
- p1 write to 0x0000_0022, be=1111, wdata=0x11223344 -> o_mem_we=1 in cycle 1 with o_mem_addr=0x20; o_p1_ack at cycle 2; readback gives 0x11223344.
- Memory 0xAABBCCDD, p1 write with be=0010, wdata=0x00005500 -> RMW: o_mem_wdata=0xAABB55DD in cycle 2; ack at cycle 3.
- p0 and p1 both requesting continuously -> grants alternate p0, p1, p0, p1; with MEMORY_ARBITER_DATA_PRIORITY_EN, p1 is served on every grant and p0 starves.
- p1 write with be=0000 -> no o_mem_we pulse; ack at cycle 2.
- Reset asserted during RMW_READ -> all outputs return to reset values immediately; memory contents unchanged; no ack.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared types and helpers for the two-port memory arbiter:
//     state_t      - arbiter FSM states
//     PORT_FETCH   - index of the instruction-fetch port (read-only)
//     PORT_DATA    - index of the load/store port (read/write, byte enables)
//     be_width()   - number of byte lanes in a memory word
//     align_bits() - number of low address bits that select a byte lane
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        DONE
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int align_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/memory_arbiter_byte_merge.sv
// ---------------------------------------------------------------------------
// byte_merge
//   Combinational byte-lane merge for partial-word stores. Each byte of the
//   result comes from new_word where the matching be bit is set, otherwise
//   from old_word. Also used by the LSU store path.
//   Ports:
//     old_word  in  DATA_WIDTH     word currently held in memory
//     new_word  in  DATA_WIDTH     store data
//     be        in  DATA_WIDTH/8   byte enables (1 = take new byte)
//     merged    out DATA_WIDTH     merged word
// ---------------------------------------------------------------------------
module byte_merge
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]           old_word,
    input  logic [DATA_WIDTH-1:0]           new_word,
    input  logic [be_width(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]           merged
);

    localparam int BE_W = be_width(DATA_WIDTH);

    always_comb begin
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Shares one word-wide memory (asynchronous read, synchronous write, no
//   byte enables) between an instruction-fetch port (port 0, read-only) and
//   a load/store port (port 1, read/write with byte enables). Partial-word
//   stores become a read-modify-write sequence.
//
//   Simultaneous requests are served round-robin. Defining
//   MEMORY_ARBITER_DATA_PRIORITY_EN makes port 1 always win instead
//   (last_grant is still tracked but not consulted).
//
//   Ports:
//     i_clock, i_reset          clock, asynchronous active-high reset
//     i_p0_req/addr             fetch request, byte address
//     o_p0_ack/rdata            fetch done pulse, read data
//     i_p1_req/addr/we/be/wdata load/store request
//     o_p1_ack/rdata            load/store done pulse, load data
//     o_mem_addr/we/wdata       memory address (word aligned), write strobe, data
//     i_mem_rdata               memory read data, combinational from o_mem_addr
// ---------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            i_clock,
    input  logic                            i_reset,

    input  logic                            i_p0_req,
    input  logic [ADDR_WIDTH-1:0]           i_p0_addr,
    output logic                            o_p0_ack,
    output logic [DATA_WIDTH-1:0]           o_p0_rdata,

    input  logic                            i_p1_req,
    input  logic [ADDR_WIDTH-1:0]           i_p1_addr,
    input  logic                            i_p1_we,
    input  logic [be_width(DATA_WIDTH)-1:0] i_p1_be,
    input  logic [DATA_WIDTH-1:0]           i_p1_wdata,
    output logic                            o_p1_ack,
    output logic [DATA_WIDTH-1:0]           o_p1_rdata,

    output logic [ADDR_WIDTH-1:0]           o_mem_addr,
    output logic                            o_mem_we,
    output logic [DATA_WIDTH-1:0]           o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]           i_mem_rdata
);

    localparam int BE_W    = be_width(DATA_WIDTH);
    localparam int ALIGN_W = align_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << ALIGN_W) - 1);

    state_t                 state;
    state_t                 next_state;

    logic                   lat_port;
    logic                   lat_we;
    logic [BE_W-1:0]        lat_be;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [DATA_WIDTH-1:0]  old_word;
    logic [DATA_WIDTH-1:0]  merged_word;
    logic                   last_grant;

    logic                   grant_valid;
    logic                   grant_port;
    logic                   grant_we;
    logic [BE_W-1:0]        grant_be;

    // ---------------------------------------------------------------------
    // Arbitration (only acted on in IDLE)
    // ---------------------------------------------------------------------
    always_comb begin
        grant_valid = i_p0_req | i_p1_req;
`ifdef MEMORY_ARBITER_DATA_PRIORITY_EN
        grant_port  = i_p1_req ? PORT_DATA : PORT_FETCH;
`else
        if (i_p0_req && i_p1_req) begin
            // Round-robin: the port that did not win last time goes first.
            grant_port = ~last_grant;
        end else begin
            grant_port = i_p1_req ? PORT_DATA : PORT_FETCH;
        end
`endif
        grant_we = (grant_port == PORT_DATA) && i_p1_we;
        grant_be = (grant_port == PORT_DATA) ? i_p1_be : '0;
    end

    byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .old_word   (old_word),
        .new_word   (lat_wdata),
        .be         (lat_be),
        .merged     (merged_word)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and memory/ack outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        next_state  = state;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_p0_ack    = 1'b0;
        o_p1_ack    = 1'b0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    // A write with no lanes enabled touches nothing: treat as a read.
                    if (!grant_we || grant_be == '0) begin
                        next_state = READ;
                    end else if (&grant_be) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RMW_READ;
                    end
                end
            end
            READ: begin
                next_state = DONE;
            end
            WRITE: begin
                o_mem_we    = 1'b1;
                o_mem_wdata = lat_wdata;
                next_state  = DONE;
            end
            RMW_READ: begin
                next_state = RMW_WRITE;
            end
            RMW_WRITE: begin
                o_mem_we    = 1'b1;
                o_mem_wdata = merged_word;
                next_state  = DONE;
            end
            DONE: begin
                o_p0_ack   = (lat_port == PORT_FETCH);
                o_p1_ack   = (lat_port == PORT_DATA);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Transaction latches and read-data registers
    // ---------------------------------------------------------------------
    // NOTE: these are a handful of flops, not a memory array, so all of them
    // take the reset; that keeps o_mem_addr and the rdata outputs at zero
    // after reset without relying on the FSM to mask them.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lat_port   <= PORT_FETCH;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_wdata  <= '0;
            old_word   <= '0;
            last_grant <= PORT_DATA;
            o_mem_addr <= '0;
            o_p0_rdata <= '0;
            o_p1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_port   <= grant_port;
                        last_grant <= grant_port;
                        lat_we     <= grant_we;
                        lat_be     <= grant_be;
                        lat_wdata  <= i_p1_wdata;
                        o_mem_addr <= ((grant_port == PORT_DATA) ? i_p1_addr : i_p0_addr)
                                      & ALIGN_MASK;
                    end
                end
                READ: begin
                    // A be=0 store also passes through READ; it must not
                    // disturb the load data register.
                    if (lat_port == PORT_FETCH) begin
                        o_p0_rdata <= i_mem_rdata;
                    end else if (!lat_we) begin
                        o_p1_rdata <= i_mem_rdata;
                    end
                end
                RMW_READ: begin
                    old_word <= i_mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
